// File: rtl/shift_deserializer_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the serial-to-parallel receiver.
// Default word width matches the parallel-load shift register.
package shift_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_BW_DATA = 8;
  localparam int BW_CNT      = $clog2(DEF_BW_DATA);

  // Bit-counter width for a given word width, never below one bit.
  function automatic int cnt_width(input int bw);
    return (bw <= 2) ? 1 : $clog2(bw);
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
`timescale 1ns/1ps
// Output word register with valid/ready handoff.
// Drops words that arrive while a stalled word is held.
module word_hold_reg #(
  parameter int BW_DATA = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [BW_DATA-1:0] data_i,
  input  logic               ready_i,
  input  logic               clr_ovr_i,
  output logic [BW_DATA-1:0] q_o,
  output logic               valid_o,
  output logic               overrun_o
);

  logic [BW_DATA-1:0] q_q, q_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               xfer;
  logic               accept;

  assign xfer   = valid_q && ready_i;
  assign accept = !valid_q || ready_i;

  // Next word/valid/overrun; load wins over a same-cycle transfer.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load_i && accept) begin
      q_d     = data_i;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (load_i && !accept) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  // Register the held word and its flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/shift_deserializer.sv
`timescale 1ns/1ps
// Framed serial-to-parallel receiver.
// FSM, bit counter and shift register feed the word hold register.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int BW_DATA   = DEF_BW_DATA,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               i_Clk,
  input  logic               i_Rstn,
  input  logic               i_Sin,
  input  logic               i_SinValid,
  input  logic               i_Frame,
  output logic [BW_DATA-1:0] o_Qout,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic               o_Busy,
  output logic               o_Overrun,
  input  logic               i_ClrOvr,
  output logic               o_FrameErr
);

  localparam int CW = cnt_width(BW_DATA);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BW_DATA - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW_DATA-1:0] sreg_q, sreg_d;
  logic [BW_DATA-1:0] base;
  logic [BW_DATA-1:0] shifted;
  logic               ferr_q, ferr_d;
  logic               done;

  // Shift the incoming bit in; a frame start shifts into a cleared word.
  always_comb begin
    base = sreg_q;
    if (state_q == IDLE || i_Frame) begin
      base = '0;
    end
    if (MSB_FIRST) begin
      shifted = {base[BW_DATA-2:0], i_Sin};
    end else begin
      shifted = {i_Sin, base[BW_DATA-1:1]};
    end
  end

  // Next-state logic: frame start, shifting, abort and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_SinValid && i_Frame) begin
          sreg_d  = shifted;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_SinValid) begin
          sreg_d = shifted;
          if (i_Frame) begin
            cnt_d  = CNT_ONE;
            ferr_d = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, shift register and abort pulse.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      ferr_q  <= ferr_d;
    end
  end

  word_hold_reg #(
    .BW_DATA (BW_DATA)
  ) u_hold (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rstn),
    .load_i    (done),
    .data_i    (shifted),
    .ready_i   (i_Ready),
    .clr_ovr_i (i_ClrOvr),
    .q_o       (o_Qout),
    .valid_o   (o_Valid),
    .overrun_o (o_Overrun)
  );

  assign o_Busy     = (state_q == SHIFT);
  assign o_FrameErr = ferr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
`timescale 1ns/1ps
// Bench for shift_deserializer: both bit orders side by side,
// checked each cycle against a bit-queue reference model.
module tb_shift_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sin = 1'b0;
  logic sv = 1'b0;
  logic fr = 1'b0;
  logic rdy = 1'b0;
  logic clr = 1'b0;

  logic [W-1:0] qm, ql;
  logic vm, vl, bm, bl, om, ol, em, el;

  shift_deserializer #(.BW_DATA(W), .MSB_FIRST(1'b1)) dut (
    .i_Clk(clk), .i_Rstn(rstn), .i_Sin(sin), .i_SinValid(sv),
    .i_Frame(fr), .o_Qout(qm), .o_Valid(vm), .i_Ready(rdy),
    .o_Busy(bm), .o_Overrun(om), .i_ClrOvr(clr), .o_FrameErr(em)
  );

  shift_deserializer #(.BW_DATA(W), .MSB_FIRST(1'b0)) dut_lsb (
    .i_Clk(clk), .i_Rstn(rstn), .i_Sin(sin), .i_SinValid(sv),
    .i_Frame(fr), .o_Qout(ql), .o_Valid(vl), .i_Ready(rdy),
    .o_Busy(bl), .o_Overrun(ol), .i_ClrOvr(clr), .o_FrameErr(el)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit         bits[$];
  bit         act;
  logic [7:0] mq_m, mq_l;
  bit         mv, mo, me;
  int         busy_cnt, ferr_cnt;
  logic [7:0] xfer[$];

  typedef struct {
    logic [7:0] w;
    logic [7:0] em;
    logic [7:0] el;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    act  = 0;
    mq_m = '0;
    mq_l = '0;
    mv   = 0;
    mo   = 0;
    me   = 0;
  endtask

  task automatic step(input logic s, input logic v, input logic f,
                      input logic r, input logic c);
    logic [7:0] wm, wl;
    bit done, acc, me_n;
    @(negedge clk);
    sin = s; sv = v; fr = f; rdy = r; clr = c;
    #1;
    if (vm && r) xfer.push_back(qm);
    @(posedge clk);
    done = 0;
    wm   = '0;
    wl   = '0;
    me_n = act && v && f;
    if (v) begin
      if (f) begin
        bits.delete();
        bits.push_back(s);
        act = 1;
      end else if (act) begin
        bits.push_back(s);
      end
    end
    if (bits.size() == W) begin
      done = 1;
      foreach (bits[i]) begin
        if (bits[i]) begin
          wm[W-1-i] = 1'b1;
          wl[i]     = 1'b1;
        end
      end
      bits.delete();
      act = 0;
    end
    acc = !mv || r;
    if (done && acc) begin
      mq_m = wm;
      mq_l = wl;
      mv   = 1;
    end else if (mv && r) begin
      mv = 0;
    end
    if (done && !acc) mo = 1;
    else if (c) mo = 0;
    me = me_n;
    #1;
    chk("qout_msb", qm, mq_m);
    chk("qout_lsb", ql, mq_l);
    chk("valid_msb", vm, mv);
    chk("valid_lsb", vl, mv);
    chk("busy_msb", bm, act);
    chk("busy_lsb", bl, act);
    chk("ovr_msb", om, mo);
    chk("ovr_lsb", ol, mo);
    chk("ferr_msb", em, me);
    chk("ferr_lsb", el, me);
    if (bm) busy_cnt++;
    if (em) ferr_cnt++;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r,
                           input int gap);
    for (int i = 0; i < W; i++) begin
      step(w[W-1-i], 1'b1, i == 0, r, 1'b0);
      if (gap > 0 && (i == 1 || i == 4)) begin
        repeat (gap) step(1'b1, 1'b0, 1'b0, r, 1'b0);
      end
    end
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'h96, 8'h96, 8'h69};
    tbl[1] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[2] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[3] = '{8'h12, 8'h12, 8'h48};
    tbl[4] = '{8'h01, 8'h01, 8'h80};
    tbl[5] = '{8'hF0, 8'hF0, 8'h0F};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_qout", {qm, ql}, 16'h0000);
    chk("rst_flags", {vm, bm, om, em, vl, bl, ol, el}, 8'h00);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      busy_cnt = 0;
      send_word(tbl[i].w, 1'b1, 0);
      chk("tbl_msb", qm, tbl[i].em);
      chk("tbl_lsb", ql, tbl[i].el);
      chk("tbl_valid", vm, 1'b1);
      if (i == 0) chk("busy_cycles", busy_cnt, 7);
      idle(1'b1);
      chk("tbl_valid_fall", vm, 1'b0);
    end

    ferr_cnt = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("stray_busy", bm, 1'b0);
    send_word(8'h96, 1'b1, 3);
    chk("gap_word", qm, 8'h96);
    chk("gap_ferr", ferr_cnt, 0);
    idle(1'b1);

    send_word(8'hA5, 1'b0, 0);
    send_word(8'h3C, 1'b0, 0);
    chk("ovr_hold", qm, 8'hA5);
    chk("ovr_flag", om, 1'b1);
    idle(1'b1);
    chk("ovr_drain", vm, 1'b0);
    chk("ovr_sticky", om, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", om, 1'b0);

    xfer.delete();
    send_word(8'h12, 1'b1, 0);
    send_word(8'h34, 1'b1, 0);
    idle(1'b1);
    idle(1'b1);
    chk("b2b_count", xfer.size(), 2);
    if (xfer.size() == 2) begin
      chk("b2b_w0", xfer[0], 8'h12);
      chk("b2b_w1", xfer[1], 8'h34);
    end
    chk("b2b_ovr", om, 1'b0);

    ferr_cnt = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
    send_word(8'hC3, 1'b1, 0);
    chk("abort_pulses", ferr_cnt, 1);
    chk("abort_word", qm, 8'hC3);
    chk("abort_lsb", ql, 8'hC3);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
    chk("pre_rst_busy", bm, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_q", {qm, ql}, 16'h0000);
    chk("async_rst_f", {vm, bm, om, em, vl, bl, ol, el}, 8'h00);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    ferr_cnt = 0;
    send_word(8'h5A, 1'b1, 0);
    chk("post_rst_word", qm, 8'h5A);
    chk("post_rst_ferr", ferr_cnt, 0);
    chk("post_rst_ovr", om, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's parallel-load shift register running in parallel-to-serial mode.
- Collects a framed serial bitstream into BW_DATA-bit words.
- Presents each completed word on a valid/ready output register.
- Flags overrun when the consumer stalls, and flags frame error when a new frame aborts a partial word.
- Sits between a serial link, or the shift register's o_Sout, and a word-oriented consumer.

Parameters:
- BW_DATA, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, bit order. 1 means the first received bit lands in Qout[BW_DATA-1]; 0 means it lands in Qout[0].

Ports:
- i_Clk  input  1  system clock; all state changes on the rising edge.
- i_Rstn  input  1  asynchronous active-low reset.
- i_Sin  input  1  serial data bit; sampled only when i_SinValid=1.
- i_SinValid  input  1  bit strobe; one bit is consumed per cycle when high.
- i_Frame  input  1  start-of-frame; qualified by i_SinValid; marks the first bit of a word.
- o_Qout  output  BW_DATA  received word; stable while o_Valid=1.
- o_Valid  output  1  word available.
- i_Ready  input  1  consumer accepts; a transfer occurs when o_Valid&&i_Ready.
- o_Busy  output  1  high while a word is partially received (state SHIFT).
- o_Overrun  output  1  sticky; a completed word was dropped.
- i_ClrOvr  input  1  clears o_Overrun.
- o_FrameErr  output  1  one-cycle pulse; a partial word was aborted by i_Frame.

Behaviour:
- Reset (i_Rstn=0, async): state IDLE, bit counter=0, shift reg=0, o_Qout=0, o_Valid=0, o_Busy=0, o_Overrun=0, o_FrameErr=0. Reset asserted mid-word discards the partial word; no o_Valid and no o_FrameErr are produced.
- The block uses two states, IDLE and SHIFT, and a counter of width $clog2(BW_DATA).
- IDLE:
  - i_SinValid&&i_Frame: store bit 0, cnt=1, go to SHIFT.
  - i_SinValid without i_Frame: bit ignored, no flag raised.
  - i_SinValid=0: hold.
- SHIFT, with i_SinValid=0: hold all state (gaps of any length allowed).
- SHIFT, with i_SinValid&&i_Frame: restart. Discard the partial word, store the current bit as bit 0, cnt=1, stay in SHIFT, o_FrameErr=1 next cycle. i_Frame takes precedence even when cnt=BW_DATA-1.
- SHIFT, with i_SinValid and no i_Frame:
  - MSB_FIRST=1: sreg <= {sreg[BW_DATA-2:0], i_Sin}.
  - MSB_FIRST=0: sreg <= {i_Sin, sreg[BW_DATA-1:1]}.
  - cnt increments.
- Completion: when cnt=BW_DATA-1 and the last bit is accepted, the assembled word (sreg including this bit) goes to the output register, cnt=0, state returns to IDLE.
- Latency: o_Valid rises and o_Qout updates on the edge that samples the last bit, so they are visible the cycle after the last bit is presented.
- Output register:
  - On completion it loads if o_Valid=0, or if o_Valid&&i_Ready in the same cycle (back-to-back with no bubble).
  - Otherwise the new word is dropped, o_Qout/o_Valid are unchanged, and o_Overrun is set on the next cycle.
  - o_Valid clears after a transfer unless a new word loads in the same cycle.
- o_Overrun: sticky. i_ClrOvr clears it. Set and clear in the same cycle resolves to set.
- o_Busy equals (state==SHIFT).
- o_FrameErr is high for exactly one cycle per abort.
- A new frame may start in the cycle right after completion; there is no minimum idle time.

Decomposition:
- Package shift_deserializer_pkg holds:
  - the state encoding (IDLE=1'b0, SHIFT=1'b1);
  - localparam BW_CNT=$clog2(BW_DATA);
  - the default BW_DATA, shared with the shift register bench.
- Sub-module word_hold_reg holds the BW_DATA output register, the o_Valid/i_Ready transfer logic and overrun detection.
- The FSM, counter and shift register live in the top module.

Test Plan:
- Serial-to-parallel: BW_DATA=8, MSB_FIRST=1, send bits 1,0,0,1,0,1,1,0 on consecutive cycles with i_Frame on the first and i_Ready=1 -> one cycle after the 8th bit, o_Qout=8'h96 and o_Valid=1 for one cycle; o_Busy is high for 7 cycles.
- Bit order: MSB_FIRST=0, same bits -> o_Qout=8'h69.
- Gaps: the same 8'h96 word with i_SinValid=0 for 3 cycles after bits 2 and 5, plus stray valid bits without i_Frame beforehand -> o_Qout=8'h96; stray bits ignored; o_FrameErr stays 0.
- Backpressure/overrun:
  - Send with i_Ready=0: 8'hA5 then 8'h3C -> o_Qout holds 8'hA5, o_Overrun=1.
  - Raise i_Ready for 1 cycle -> o_Valid falls.
  - Pulse i_ClrOvr -> o_Overrun=0.
  - Back-to-back: 8'h12 then 8'h34 with i_Ready=1 -> both delivered, no overrun.
- Frame abort: send 5 bits, then assert i_Frame with a new frame 8'hC3 -> o_FrameErr pulses once, and o_Qout=8'hC3 after 8 more bits.
- Reset mid-word: drop i_Rstn asynchronously after 4 bits -> all outputs are 0 immediately. After release, a full frame 8'h5A -> o_Qout=8'h5A with no error flags.
